// File: rtl/mod3_pkg.sv
// Shared mod-3 definitions for the frame serializer and the serial multiple-of-three detector.
package mod3_pkg;

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  localparam logic [1:0] REM0 = 2'd0;
  localparam logic [1:0] REM1 = 2'd1;
  localparam logic [1:0] REM2 = 2'd2;

  // rem' = (2*rem + b) mod 3
  function automatic logic [1:0] mod3_next(input logic [1:0] rem, input logic b);
    case (rem)
      REM0:    return b ? REM1 : REM0;
      REM1:    return b ? REM0 : REM2;
      default: return b ? REM2 : REM1;
    endcase
  endfunction

  // Two trailing bits c with (4*rem + c) mod 3 == 0, MSB-first
  function automatic logic [1:0] mod3_check(input logic [1:0] rem);
    case (rem)
      REM1:    return 2'b10;
      REM2:    return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mod3_rem_tracker.sv
// Registered running mod-3 remainder; clear restarts from 0, and clear+advance folds the first bit in.
module mod3_rem_tracker
  import mod3_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  input  logic       data_bit,
  output logic [1:0] rem
);

  logic [1:0] base;

  assign base = clear ? REM0 : rem;

  always_ff @(posedge clk) begin
    if (reset)
      rem <= REM0;
    else if (advance)
      rem <= mod3_next(base, data_bit);
    else if (clear)
      rem <= REM0;
  end

endmodule

// File: rtl/mod3_frame_serializer.sv
// Shifts a DATA_W-bit word out MSB-first and appends 2 check bits so each frame is divisible by 3.
// Optional MOD3_REM_DBG_EN adds the rem_dbg output (registered running remainder).
module mod3_frame_serializer
  import mod3_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_sof,
  output logic              ser_eof
`ifdef MOD3_REM_DBG_EN
  ,
  output logic [1:0]        rem_dbg
`endif
);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [1:0]        rem;
  logic [1:0]        chk;
  logic              accept, last_data, last_chk;
  logic              rem_clear, rem_adv, rem_bit;

  assign last_data = (cnt == CNT_W'(DATA_W - 1));
  assign last_chk  = (cnt == CNT_W'(1));
  assign accept    = in_valid && in_ready;
  assign chk       = mod3_check(rem);

  // rem always includes the payload bit currently on ser_out, so the first bit is folded in at accept
  assign rem_clear = accept || (state == CHECK && last_chk);
  assign rem_adv   = accept || (state == DATA && !last_data);
  assign rem_bit   = accept ? in_data[DATA_W-1] : shreg[DATA_W-2];

  mod3_rem_tracker u_rem (
    .clk      (clk),
    .reset    (reset),
    .clear    (rem_clear),
    .advance  (rem_adv),
    .data_bit (rem_bit),
    .rem      (rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    in_ready  = 1'b0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    ser_sof   = 1'b0;
    ser_eof   = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
      end
      DATA: begin
        ser_valid = 1'b1;
        ser_out   = shreg[DATA_W-1];
        ser_sof   = (cnt == '0);
        shreg_n   = {shreg[DATA_W-2:0], 1'b0};
        if (last_data) begin
          state_n = CHECK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        ser_valid = 1'b1;
        ser_out   = last_chk ? chk[0] : chk[1];
        ser_eof   = last_chk;
        in_ready  = last_chk;
        if (last_chk) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Accept is only possible in IDLE or the eof cycle and overrides both
    if (accept) begin
      state_n = DATA;
      cnt_n   = '0;
      shreg_n = in_data;
    end
  end

`ifdef MOD3_REM_DBG_EN
  assign rem_dbg = rem;
`endif

endmodule

// File: doc/mod3_frame_serializer.md
Name: mod3_frame_serializer

Overview:
- Transmit-side counterpart of the team's serial multiple-of-three detector.
- Accepts a parallel DATA_W-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Appends 2 check bits so the full (DATA_W+2)-bit frame, read as an unsigned MSB-first integer, is divisible by 3.
- A downstream mod-3 detector that is reset at frame start must therefore report "multiple of three" on the final bit of every frame.

Parameters:
- DATA_W, 8: payload width in bits (must be at least 2).
- CNT_W, $clog2(DATA_W+2): width of the internal bit-position counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  payload word; sampled when in_valid && in_ready.
- ser_out  output  1  serial bit, MSB-first.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- ser_sof  output  1  high on the first payload bit of a frame.
- ser_eof  output  1  high on the last check bit of a frame.

Behaviour:
- All outputs come from registers or state decode. There is no combinational path from in_valid or in_data to ser_*.
- Reset: state=IDLE, rem=0, counter=0, ser_out=0, ser_valid=0, ser_sof=0, ser_eof=0, in_ready=1 in the cycle after reset deasserts.
- Reset has priority over everything. Asserting it mid-frame aborts the frame immediately: no eof and no partial check bits.
- States:
  - IDLE: ser_valid=0, in_ready=1. An accept moves to DATA.
  - DATA: DATA_W cycles, one payload bit per cycle. After bit DATA_W-1, move to CHECK.
  - CHECK: 2 cycles. After the second bit, go to DATA if a word was accepted that cycle, else IDLE.
- Accept: occurs on any edge where in_valid && in_ready.
  - The shift register loads in_data and rem clears to 0.
  - The first payload bit appears on ser_out in the next cycle, with ser_sof=1.
- Running remainder: rem' = (2*rem + bit) mod 3, updated for each payload bit.
  - Transitions: 0 -0->0, 0 -1->1, 1 -0->2, 1 -1->0, 2 -0->1, 2 -1->2.
- Check bits: chosen from the final payload rem and emitted MSB-first.
  - rem=0 -> 00; rem=1 -> 10; rem=2 -> 01.
  - This satisfies (4*rem + c) mod 3 = 0.
- in_ready is 1 in IDLE and during the second CHECK cycle (the eof cycle); it is 0 otherwise.
  - An accept in the eof cycle gives gapless back-to-back frames: the next sof immediately follows eof.
- Frame length: exactly DATA_W+2 consecutive ser_valid cycles.
- in_valid is ignored while in_ready=0. in_data is not required to stay stable once accepted.

Optional Feature:
- MOD3_REM_DBG_EN defined: adds output port rem_dbg [1:0], carrying the registered running remainder. It is held at 0 while idle or in reset.
- Not defined: the port and its logic are absent. Frame behaviour is identical either way.

Decomposition:
- Package mod3_pkg holds:
  - state enum {IDLE, DATA, CHECK};
  - remainder constants REM0/REM1/REM2;
  - function mod3_next(rem, bit);
  - function mod3_check(rem) returning the 2 check bits.
- Package mod3_pkg is shared with the detector.
- One sub-module is natural: mod3_rem_tracker, a registered remainder with clear and advance inputs, reused by future receive-side checkers.

Test Plan:
- Encode 0x01 (rem 1): stream 00000001_10 (=6); ser_sof on bit 0, ser_eof on bit 9; a mod-3 detector fed this stream reports 1 on bit 9.
- Encode 0x02 (rem 2) -> 00000010_01 (=9); encode 0x03 and 0xFF (rem 0) -> check bits 00; the detector reports 1 at eof in all cases.
- Back-to-back: hold in_valid=1 with 0xA5 then 0x5A -> 20 consecutive ser_valid cycles, second sof the cycle after first eof, in_ready high only in IDLE and eof cycles.
- Backpressure: pulse in_valid during the DATA phase -> not accepted, stream unchanged, in_data changes ignored.
- Reset mid-frame at payload bit 4 -> next cycle ser_valid=0, in_ready=1, rem=0; a following 0x01 encodes cleanly as 00000001_10.
- With MOD3_REM_DBG_EN, input 0x06 -> rem_dbg sequence 0,0,0,0,0,1,0,0 over the payload bits, then check bits 00.
